// File: rtl/bc_datapath.sv
// Basic-computer datapath: register file, common bus, ALU and word memory.
// All state changes on the rising edge of clk; rst is synchronous, active-high.
// Optional feature macro: BC_OUTR_EN adds an 8-bit output register loaded from
// bus[7:0] on OUTR_LD. Without it OUTR is tied to zero and OUTR_LD is ignored.
module bc_datapath #(
   parameter int WIDTH      = 16,
   parameter int CTRL_LNGTH = 21,
   parameter int ADDR_W     = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        BUS_SEL,
   input  logic [2:0]        CTRL_SGNLS [0:CTRL_LNGTH-1],
   output logic [WIDTH-1:0]  IR,
   output logic [WIDTH-1:0]  AC,
   output logic [WIDTH-1:0]  DR,
   output logic [WIDTH-1:0]  TR,
   output logic [ADDR_W-1:0] AR,
   output logic [ADDR_W-1:0] PC,
   output logic              E,
   output logic [7:0]        OUTR
);

   localparam int I_AR_LD   = 0;
   localparam int I_AR_INR  = 1;
   localparam int I_AR_CLR  = 2;
   localparam int I_MEM_WR  = 3;
   localparam int I_IR_LD   = 4;
   localparam int I_DR_LD   = 5;
   localparam int I_DR_INR  = 6;
   localparam int I_DR_CLR  = 7;
   localparam int I_TR_LD   = 8;
   localparam int I_AC_LD   = 9;
   localparam int I_AC_INR  = 10;
   localparam int I_AC_CLR  = 11;
   localparam int I_PC_INR  = 12;
   localparam int I_PC_LD   = 13;
   localparam int I_PC_CLR  = 14;
   localparam int I_TR_INR  = 15;
   localparam int I_TR_CLR  = 16;
   localparam int I_OUTR_LD = 17;
   localparam int I_E_CMP   = 18;
   localparam int I_E_CLR   = 19;
   localparam int I_ALU_OP  = 20;

   logic [WIDTH-1:0] mem [0:(2**ADDR_W)-1];
   logic [WIDTH-1:0] mem_rd;
   logic [WIDTH-1:0] bus;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_val;
   logic             alu_e;
   logic             alu_e_upd;
   logic             alu_valid;
   logic [2:0]       alu_op;
   logic             unused_ctl;

   logic ar_ld, ar_inr, ar_clr, mem_wr, ir_ld;
   logic dr_ld, dr_inr, dr_clr, tr_ld, tr_inr, tr_clr;
   logic ac_ld, ac_inr, ac_clr, pc_ld, pc_inr, pc_clr;
   logic e_cmp, e_clr;

   // Only bit 0 of each strobe entry is meaningful; the ALU op uses all three bits.
   assign ar_ld  = CTRL_SGNLS[I_AR_LD][0];
   assign ar_inr = CTRL_SGNLS[I_AR_INR][0];
   assign ar_clr = CTRL_SGNLS[I_AR_CLR][0];
   assign mem_wr = CTRL_SGNLS[I_MEM_WR][0];
   assign ir_ld  = CTRL_SGNLS[I_IR_LD][0];
   assign dr_ld  = CTRL_SGNLS[I_DR_LD][0];
   assign dr_inr = CTRL_SGNLS[I_DR_INR][0];
   assign dr_clr = CTRL_SGNLS[I_DR_CLR][0];
   assign tr_ld  = CTRL_SGNLS[I_TR_LD][0];
   assign ac_ld  = CTRL_SGNLS[I_AC_LD][0];
   assign ac_inr = CTRL_SGNLS[I_AC_INR][0];
   assign ac_clr = CTRL_SGNLS[I_AC_CLR][0];
   assign pc_inr = CTRL_SGNLS[I_PC_INR][0];
   assign pc_ld  = CTRL_SGNLS[I_PC_LD][0];
   assign pc_clr = CTRL_SGNLS[I_PC_CLR][0];
   assign tr_inr = CTRL_SGNLS[I_TR_INR][0];
   assign tr_clr = CTRL_SGNLS[I_TR_CLR][0];
   assign e_cmp  = CTRL_SGNLS[I_E_CMP][0];
   assign e_clr  = CTRL_SGNLS[I_E_CLR][0];
   assign alu_op = CTRL_SGNLS[I_ALU_OP];

   // Fold every control bit so the ignored upper strobe bits are still referenced.
   always_comb begin
      unused_ctl = 1'b0;
      for (int i = 0; i < CTRL_LNGTH; i++) begin
         unused_ctl = unused_ctl ^ (^CTRL_SGNLS[i]);
      end
   end

   // Asynchronous read from the current AR; a same-edge write is not visible yet.
   assign mem_rd = mem[AR];

   // Common bus source select.
   always_comb begin
      bus = '0;
      case (BUS_SEL)
         3'b000:  bus = '0;
         3'b001:  bus = WIDTH'(AR);
         3'b010:  bus = WIDTH'(PC);
         3'b011:  bus = DR;
         3'b100:  bus = IR;
         3'b101:  bus = AC;
         3'b110:  bus = mem_rd;
         default: bus = TR;
      endcase
   end

   assign sum = {1'b0, AC} + {1'b0, DR};

   // ALU result and the E side effect of the selected operation.
   always_comb begin
      alu_val   = AC;
      alu_e     = E;
      alu_e_upd = 1'b0;
      alu_valid = 1'b1;
      case (alu_op)
         3'b000: alu_val = AC & DR;
         3'b001: begin
            alu_val   = sum[WIDTH-1:0];
            alu_e     = sum[WIDTH];
            alu_e_upd = 1'b1;
         end
         3'b010: alu_val = DR;
         3'b011: alu_val = ~AC;
         3'b100: begin
            alu_val   = {AC[WIDTH-2:0], E};
            alu_e     = AC[WIDTH-1];
            alu_e_upd = 1'b1;
         end
         3'b101: begin
            alu_val   = {E, AC[WIDTH-1:1]};
            alu_e     = AC[0];
            alu_e_upd = 1'b1;
         end
         default: alu_valid = 1'b0;
      endcase
   end

   // Memory write targets the AR value from before the edge; blocked during reset.
   always_ff @(posedge clk) begin
      if (!rst && mem_wr) begin
         mem[AR] <= bus;
      end
   end

   // AR: clear > load > increment.
   always_ff @(posedge clk) begin
      if (rst)         AR <= '0;
      else if (ar_clr) AR <= '0;
      else if (ar_ld)  AR <= bus[ADDR_W-1:0];
      else if (ar_inr) AR <= AR + ADDR_W'(1);
   end

   // PC: clear > load > increment.
   always_ff @(posedge clk) begin
      if (rst)         PC <= '0;
      else if (pc_clr) PC <= '0;
      else if (pc_ld)  PC <= bus[ADDR_W-1:0];
      else if (pc_inr) PC <= PC + ADDR_W'(1);
   end

   // DR: clear > load > increment.
   always_ff @(posedge clk) begin
      if (rst)         DR <= '0;
      else if (dr_clr) DR <= '0;
      else if (dr_ld)  DR <= bus;
      else if (dr_inr) DR <= DR + WIDTH'(1);
   end

   // TR: clear > load > increment.
   always_ff @(posedge clk) begin
      if (rst)         TR <= '0;
      else if (tr_clr) TR <= '0;
      else if (tr_ld)  TR <= bus;
      else if (tr_inr) TR <= TR + WIDTH'(1);
   end

   // IR: full-width load from the bus.
   always_ff @(posedge clk) begin
      if (rst)        IR <= '0;
      else if (ir_ld) IR <= bus;
   end

   // AC: clear > ALU load > increment; an invalid op under load holds AC.
   always_ff @(posedge clk) begin
      if (rst)            AC <= '0;
      else if (ac_clr)    AC <= '0;
      else if (ac_ld) begin
         if (alu_valid)   AC <= alu_val;
      end
      else if (ac_inr)    AC <= AC + WIDTH'(1);
   end

   // E: clear > complement > ALU carry/shift-out (only when the AC load takes effect).
   always_ff @(posedge clk) begin
      if (rst)                                  E <= 1'b0;
      else if (e_clr)                           E <= 1'b0;
      else if (e_cmp)                           E <= ~E;
      else if (ac_ld && !ac_clr && alu_e_upd)   E <= alu_e;
   end

`ifdef BC_OUTR_EN
   logic outr_ld;
   assign outr_ld = CTRL_SGNLS[I_OUTR_LD][0];

   // Output register takes the low byte of the bus.
   always_ff @(posedge clk) begin
      if (rst)          OUTR <= 8'h00;
      else if (outr_ld) OUTR <= bus[7:0];
   end
`else
   assign OUTR = 8'h00;
`endif

endmodule

// File: doc/bc_datapath.md
BC_DATAPATH -- requirements
Module: bc_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter CTRL_LNGTH, default 21, number of control-signal entries.
REQ-003 SHALL have parameter ADDR_W, default 12, address width; memory depth 2**ADDR_W.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port BUS_SEL  input  3  common-bus source select.
REQ-007 SHALL have port CTRL_SGNLS  input  3 x CTRL_LNGTH (unpacked [0:CTRL_LNGTH-1])  control entries; bit 0 of each entry is the strobe, except entry 20, which is the full 3-bit ALU op.
REQ-008 SHALL have port IR  output  16  instruction register, returned to the controller.
REQ-009 SHALL have ports AC (16), DR (16), TR (16), AR (12), PC (12), E (1)  output  register contents.
REQ-010 SHALL have port OUTR  output  8  output register.

Function
REQ-011 Bus source SHALL be: 000 zero, 001 AR (zero-extended), 010 PC (zero-extended), 011 DR, 100 IR, 101 AC, 110 M[AR], 111 TR.
REQ-012 Control indices SHALL be: 0 AR_LD, 1 AR_INR, 2 AR_CLR, 3 MEM_WR, 4 IR_LD, 5 DR_LD, 6 DR_INR, 7 DR_CLR, 8 TR_LD, 9 AC_LD, 10 AC_INR, 11 AC_CLR, 12 PC_INR, 13 PC_LD, 14 PC_CLR, 15 TR_INR, 16 TR_CLR, 17 OUTR_LD, 18 E_CMP, 19 E_CLR, 20 ALU_OP.
REQ-013 Per register, priority SHALL be CLR > LD > INR; the loaded value is the bus value of the same cycle; AR/PC load bus[11:0].
REQ-014 INR SHALL wrap modulo register width (AC FFFF->0000, PC FFF->000).
REQ-015 Memory read SHALL be combinational from the current AR; MEM_WR SHALL write the bus value to M[old AR] at the edge, even when AR_LD is asserted in the same cycle.
REQ-016 A read of M[AR] in the same cycle as a write to M[AR] SHALL return the old contents.
REQ-017 With AC_LD asserted, ALU_OP SHALL set AC to: 000 AC&DR; 001 low 16 bits of AC+DR with carry into E; 010 DR; 011 ~AC; 100 {AC[14:0],E} with E<=AC[15]; 101 {E,AC[15:1]} with E<=AC[0]; 110 and 111 AC unchanged.
REQ-018 AC_LD without a valid op (110/111) SHALL leave AC and E unchanged; ALU ops SHALL have no effect without AC_LD.
REQ-019 E priority SHALL be E_CLR > E_CMP > ALU-driven update (ops 001/100/101).
REQ-020 IR_LD SHALL load the full 16-bit bus; IR is visible to the controller the cycle after the edge.
REQ-021 Every register update SHALL take exactly one clock; there is no stall or handshake.
REQ-022 Unused bits 1-2 of strobe entries SHALL be ignored.

Reset
REQ-023 On a rising edge with rst=1, AR, PC, DR, AC, IR, TR, OUTR and E SHALL become 0, overriding all control inputs.
REQ-024 Memory contents SHALL NOT be affected by reset, and MEM_WR SHALL be suppressed while rst=1.

Configuration
REQ-025 Macro BC_OUTR_EN: when defined, OUTR SHALL be an 8-bit register loaded from bus[7:0] on OUTR_LD.
REQ-026 When BC_OUTR_EN is undefined, no OUTR register SHALL exist, OUTR SHALL be constant 8'h00, and index 17 SHALL be ignored.

Verification
REQ-027 Apply rst for 1 cycle with all strobes set -> all outputs 0 on the next cycle.
REQ-028 Backdoor M[000]=7800; BUS_SEL=010 + AR_LD; then BUS_SEL=110 + IR_LD + PC_INR -> IR=7800, PC=001.
REQ-029 AC=FFFF, DR=0001, ALU_OP=001 + AC_LD -> AC=0000, E=1; repeat with E_CLR asserted -> AC=0000, E=0.
REQ-030 AC=8001, E=0, ALU_OP=100 + AC_LD -> AC=0002, E=1; then ALU_OP=101 -> AC=8001, E=0.
REQ-031 Assert AC_CLR, AC_LD and AC_INR together -> AC=0000; AR=005 with AR_LD from BUS_SEL=011 (DR=0ABC) and MEM_WR -> M[005]=0ABC, AR=ABC.
REQ-032 With BC_OUTR_EN defined: AC=12A5, BUS_SEL=101 + OUTR_LD -> OUTR=A5; without the macro -> OUTR=00.
